systolic_mac_sched: RTL

//  Sequencer for an N x N systolic array of 8-bit FP MAC processing elements (PEs).

---
 rtl/sa_pkg.sv | 25 ++
 rtl/sa_skew_mux.sv | 31 +++
 rtl/systolic_mac_sched.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sa_pkg.sv
// Shared definitions for the systolic MAC sequencer.
//   - Sequencer state encoding.
//   - FP8 operand field layout: 1 sign bit, 3 exponent bits, 4 mantissa bits.
//   - Default array dimension and operand width.
package sa_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StClear,
        StStream,
        StDrain,
        StDone
    } sa_state_e;

    // FP8 field positions
    localparam int unsigned SIGN_B  = 7;
    localparam int unsigned EXP_MSB = 6;
    localparam int unsigned EXP_LSB = 4;
    localparam int unsigned MAN_MSB = 3;
    localparam int unsigned MAN_LSB = 0;

    localparam int unsigned N_DEF  = 4;
    localparam int unsigned DW_DEF = 8;

endpackage

// File: rtl/sa_skew_mux.sv
// Skew selector for one array edge lane.
// Picks element (t - Lane) of the lane's operand vector.
// It returns 0 when that index falls outside 0..N-1.
// Ports:
//   t         stream step the selection is made for
//   lane_vec  the N operands of this lane, element k on [k*DW +: DW]
//             (row i: A[i][k]; column j: B[k][j])
//   elem      selected operand, or 0 when padding
module sa_skew_mux
    import sa_pkg::*;
#(
    parameter int unsigned N    = N_DEF,
    parameter int unsigned DW   = DW_DEF,
    parameter int unsigned Lane = 0,
    parameter int unsigned CntW = $clog2(3 * N)
) (
    input  logic [CntW-1:0] t,
    input  logic [N*DW-1:0] lane_vec,
    output logic [DW-1:0]   elem
);

    always_comb begin
        elem = '0;
        for (int unsigned k = 0; k < N; k++) begin
            if (t == CntW'(k + Lane)) begin
                elem = lane_vec[k*DW +: DW];
            end
        end
    end

endmodule

// File: rtl/systolic_mac_sched.sv
// Sequencer for an N x N systolic array of FP8 MAC processing elements.
// It holds the host-written A and B operand matrices.
// It clears the PE accumulators and streams the operands into the array edges with diagonal skew.
// After the PE pipeline drains, it pulses done.
// Ports:
//   clk       clock, rising edge
//   reset     synchronous active-low reset
//   wr_en     host write strobe (accepted only while idle)
//   wr_sel    0 = matrix A, 1 = matrix B
//   wr_addr   {row, col} element index
//   wr_data   element value
//   start     begin a multiply (honoured only while idle)
//   busy      high from start acceptance through the done cycle
//   done      one-cycle completion pulse
//   wr_err    one-cycle pulse: a write was dropped because the block was busy
//   pe_clr    accumulator clear to every PE
//   row_data  row i feed on [i*DW +: DW]
//   col_data  column j feed on [j*DW +: DW]
module systolic_mac_sched
    import sa_pkg::*;
#(
    parameter int unsigned N         = N_DEF,
    parameter int unsigned DW        = DW_DEF,
    parameter int unsigned DRAIN_CYC = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    wr_en,
    input  logic                    wr_sel,
    input  logic [2*$clog2(N)-1:0]  wr_addr,
    input  logic [DW-1:0]           wr_data,
    input  logic                    start,
    output logic                    busy,
    output logic                    done,
    output logic                    wr_err,
    output logic                    pe_clr,
    output logic [N*DW-1:0]         row_data,
    output logic [N*DW-1:0]         col_data
);

    localparam int unsigned AW   = $clog2(N);
    localparam int unsigned CntW = $clog2(3 * N);
    localparam int unsigned DrnW = $clog2(DRAIN_CYC + 1);
    localparam logic [CntW-1:0] LastT   = CntW'(3 * N - 3);
    localparam logic [DrnW-1:0] LastDrn = DrnW'(DRAIN_CYC - 1);

    sa_state_e        state_q, state_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic [DrnW-1:0]  drain_q, drain_d;

    logic [DW-1:0]    a_q [N][N];
    logic [DW-1:0]    b_q [N][N];

    logic [AW-1:0]    wr_row, wr_col;
    logic             wr_ok;

    logic [N*DW-1:0]  row_elem, col_elem;

    assign wr_row = wr_addr[2*AW-1:AW];
    assign wr_col = wr_addr[AW-1:0];
    assign wr_ok  = wr_en && (state_q == StIdle);
    assign busy   = (state_q != StIdle);

    // Operand buffers: a write and a start in the same idle cycle land together, so the
    // run that follows already sees the new element.
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int r = 0; r < N; r++) begin
                for (int c = 0; c < N; c++) begin
                    a_q[r][c] <= '0;
                    b_q[r][c] <= '0;
                end
            end
        end else if (wr_ok) begin
            if (wr_sel) begin
                b_q[wr_row][wr_col] <= wr_data;
            end else begin
                a_q[wr_row][wr_col] <= wr_data;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        drain_d = drain_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StClear;
                end
            end
            StClear: begin
                state_d = StStream;
                cnt_d   = '0;
            end
            StStream: begin
                if (cnt_q == LastT) begin
                    state_d = StDrain;
                    cnt_d   = '0;
                    drain_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StDrain: begin
                if (drain_q == LastDrn) begin
                    state_d = StDone;
                end else begin
                    drain_d = drain_q + 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Feeds are registered, so selection is driven by the next step count: the value lands
    // in the same cycle the counter shows that step.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [N*DW-1:0] a_row;
        logic [N*DW-1:0] b_col;
        for (genvar k = 0; k < N; k++) begin : g_elem
            assign a_row[k*DW +: DW] = a_q[i][k];
            assign b_col[k*DW +: DW] = b_q[k][i];
        end

        sa_skew_mux #(
            .N    (N),
            .DW   (DW),
            .Lane (i),
            .CntW (CntW)
        ) u_row_mux (
            .t        (cnt_d),
            .lane_vec (a_row),
            .elem     (row_elem[i*DW +: DW])
        );

        sa_skew_mux #(
            .N    (N),
            .DW   (DW),
            .Lane (i),
            .CntW (CntW)
        ) u_col_mux (
            .t        (cnt_d),
            .lane_vec (b_col),
            .elem     (col_elem[i*DW +: DW])
        );
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            drain_q  <= '0;
            pe_clr   <= 1'b0;
            done     <= 1'b0;
            wr_err   <= 1'b0;
            row_data <= '0;
            col_data <= '0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            drain_q  <= drain_d;
            pe_clr   <= (state_d == StClear);
            done     <= (state_d == StDone);
            wr_err   <= wr_en && (state_q != StIdle);
            row_data <= (state_d == StStream) ? row_elem : '0;
            col_data <= (state_d == StStream) ? col_elem : '0;
        end
    end

endmodule
